shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_op_decode.sv | 32 +++
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command sequencer.
package shift_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_AMT = 8;
  localparam int AMT_W   = 4;
  localparam int OP_W    = 3;
  localparam int CNT_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSR = 3'd0,
    OP_ASR = 3'd1,
    OP_LSL = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Saturate a requested amount so the shifter never sees more than MAX_AMT.
  function automatic logic [AMT_W-1:0] clamp_amt(input logic [AMT_W-1:0] a);
    return (a > AMT_W'(MAX_AMT)) ? AMT_W'(MAX_AMT) : a;
  endfunction

endpackage

// File: rtl/shift_op_decode.sv
// Op decode: maps a latched op code to shifter controls. Reserved codes
// become a zero-amount logical right shift, i.e. a pass-through.
module shift_op_decode
  import shift_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            ar,
  output logic            lr,
  output logic            rot,
  output logic            n_zero
);

  // Pure lookup; reserved codes fall into the default arm.
  always_comb begin
    ar     = 1'b0;
    lr     = 1'b0;
    rot    = 1'b0;
    n_zero = 1'b0;
    case (op)
      OP_LSR: ;
      OP_ASR: ar = 1'b1;
      OP_LSL: lr = 1'b1;
      OP_ROR: rot = 1'b1;
      OP_ROL: begin
        lr  = 1'b1;
        rot = 1'b1;
      end
      default: n_zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift sequencer. Latches a command, loops the accumulator through
// an external combinational shifter (cmd_reps + 1) times, then offers the byte.
// Optional feature macro: SHIFT_SEQ_DONE_CNT_EN adds an 8-bit done_cnt output
// counting result handshakes (wraps at 255).
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [CNT_W-1:0]  cmd_reps,
  output logic [DATA_W-1:0] sh_i,
  output logic [AMT_W-1:0]  sh_n,
  output logic              sh_ar,
  output logic              sh_lr,
  output logic              sh_rot,
  input  logic [DATA_W-1:0] sh_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
`ifdef SHIFT_SEQ_DONE_CNT_EN
  ,
  output logic [DATA_W-1:0] done_cnt
`endif
);

  seq_state_e        state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   op_q;
  logic [AMT_W-1:0]  amt_q;
  logic              n_zero;

  shift_op_decode u_dec (
    .op     (op_q),
    .ar     (sh_ar),
    .lr     (sh_lr),
    .rot    (sh_rot),
    .n_zero (n_zero)
  );

  // The shifter always sees the accumulator, so its output is the next step.
  assign sh_i     = acc;
  assign sh_n     = n_zero ? '0 : amt_q;
  assign res_data = acc;

  // Sequencer FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= OP_LSR;
      amt_q     <= '0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            acc       <= cmd_data;
            op_q      <= cmd_op;
            amt_q     <= clamp_amt(cmd_amt);
            cnt       <= cmd_reps;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= sh_o;
          if (cnt == '0) begin
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // acc is frozen here so res_data holds under back-pressure.
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_SEQ_DONE_CNT_EN
  // Count completed result handshakes; natural 8-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt <= '0;
    else if (res_valid && res_ready) done_cnt <= done_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the 8-bit
// funnel/barrel shifter stage wired between the sh_* ports.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_amt = '0;
  logic [2:0] cmd_reps = '0;
  logic [7:0] sh_i;
  logic [3:0] sh_n;
  logic       sh_ar, sh_lr, sh_rot;
  logic [7:0] sh_o;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;
`ifdef SHIFT_SEQ_DONE_CNT_EN
  logic [7:0] done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_reps  (cmd_reps),
    .sh_i      (sh_i),
    .sh_n      (sh_n),
    .sh_ar     (sh_ar),
    .sh_lr     (sh_lr),
    .sh_rot    (sh_rot),
    .sh_o      (sh_o),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
`ifdef SHIFT_SEQ_DONE_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  // Shifter stage model: rotate / left / arithmetic right / logical right.
  always_comb begin
    logic [15:0] dbl;
    dbl  = {sh_i, sh_i};
    sh_o = sh_i >> sh_n;
    if (sh_rot) begin
      if (sh_lr) begin
        dbl  = dbl << sh_n;
        sh_o = dbl[15:8];
      end else begin
        dbl  = dbl >> sh_n;
        sh_o = dbl[7:0];
      end
    end else if (sh_lr) begin
      sh_o = sh_i << sh_n;
    end else if (sh_ar) begin
      sh_o = $signed(sh_i) >>> sh_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [2:0] op;
    logic [3:0] amt;
    logic [2:0] reps;
    logic [3:0] n;    // amount the shifter must see
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Offer one command, wait for the result, check it and its latency, then
  // complete the result handshake. Latency counts the accept cycle as cycle 0.
  task automatic run_cmd(input vec_t v);
    int lat;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = v.data;
    cmd_op    = v.op;
    cmd_amt   = v.amt;
    cmd_reps  = v.reps;
    res_ready = 1'b0;
    chk({v.name, "_ready"}, cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    chk({v.name, "_sh_i"}, sh_i, v.data);
    chk({v.name, "_sh_n"}, sh_n, v.n);
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, "_latency"}, lat, v.reps + 2);
    chk({v.name, "_data"}, res_data, v.exp);
    chk({v.name, "_busy"}, {busy, cmd_ready}, 2'b10);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({v.name, "_post"}, {res_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [7:0] held;

    vecs[0] = '{"lsl",       8'h81, 3'd2, 4'd1,  3'd0, 4'd1, 8'h02};
    vecs[1] = '{"asr",       8'h80, 3'd1, 4'd2,  3'd2, 4'd2, 8'hFE};
    vecs[2] = '{"rol",       8'h96, 3'd4, 4'd3,  3'd1, 4'd3, 8'hA5};
    vecs[3] = '{"lsr_clamp", 8'hFF, 3'd0, 4'd12, 3'd0, 4'd8, 8'h00};
    vecs[4] = '{"ror_clamp", 8'h5A, 3'd3, 4'd12, 3'd0, 4'd8, 8'h5A};
    vecs[5] = '{"op6_pass",  8'h3C, 3'd6, 4'd3,  3'd0, 4'd0, 8'h3C};
    vecs[6] = '{"asr_15",    8'h80, 3'd1, 4'd15, 3'd0, 4'd8, 8'hFF};
    vecs[7] = '{"ror_max",   8'h01, 3'd3, 4'd1,  3'd7, 4'd1, 8'h01};
    vecs[8] = '{"lsr_max",   8'hF0, 3'd0, 4'd4,  3'd7, 4'd4, 8'h00};
    vecs[9] = '{"op7_pass",  8'hC3, 3'd7, 4'd9,  3'd2, 4'd0, 8'hC3};

    // Values while held in reset.
    #12;
    chk("rst_flags", {cmd_ready, res_valid, busy}, 3'b100);
    chk("rst_res_data", res_data, 0);
    chk("rst_sh", {sh_i, sh_n, sh_ar, sh_lr, sh_rot}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-pressure with a second command waiting on cmd_valid.
    @(negedge clk);
`ifdef SHIFT_SEQ_DONE_CNT_EN
    chk("cnt_0", done_cnt, 0);
`endif
    cmd_valid = 1'b1; cmd_data = 8'h81; cmd_op = 3'd2; cmd_amt = 4'd1; cmd_reps = 3'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_data = 8'h96; cmd_op = 3'd4; cmd_amt = 4'd3; cmd_reps = 3'd1;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 2);
    held = res_data;
    chk("bp_first", held, 8'h02);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", {res_valid, cmd_ready, res_data}, {2'b10, 8'h02});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_ready_after", {cmd_ready, res_valid}, 2'b10);
`ifdef SHIFT_SEQ_DONE_CNT_EN
    chk("cnt_1", done_cnt, 1);
`endif
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_taken", {busy, cmd_ready}, 2'b10);
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_lat", lat, 3);
    chk("bp_second", res_data, 8'hA5);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
`ifdef SHIFT_SEQ_DONE_CNT_EN
    chk("cnt_2", done_cnt, 2);
`endif

    // Table of single commands.
    for (int k = 0; k < 10; k++) run_cmd(vecs[k]);

    // Reset in the middle of a long RUN: result must be dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_op = 3'd2; cmd_amt = 4'd1; cmd_reps = 3'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_flags", {cmd_ready, res_valid, busy}, 3'b100);
    chk("mid_rst_data", {res_data, sh_i, sh_n}, 0);
    chk("mid_rst_ctl", {sh_ar, sh_lr, sh_rot}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    res_ready = 1'b0;
    chk("no_result_after_rst", seen, 0);
    chk("post_rst_idle", {cmd_ready, res_data}, {1'b1, 8'h00});
`ifdef SHIFT_SEQ_DONE_CNT_EN
    chk("cnt_rst", done_cnt, 0);
`endif
    run_cmd(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
